// File: rtl/emesh_pkg.sv
// Shared emesh definitions: packet field layout, datamode encodings and
// the packet-width rule PW = 2*AW + 40.
package emesh_pkg;

  localparam int EMESH_AW = 32;

  function automatic int pw_of(input int aw);
    return 2 * aw + 40;
  endfunction

  localparam int EMESH_PW = pw_of(EMESH_AW);

  // Bit offsets of each field inside a packet (AW = 32).
  localparam int WRITE_BIT    = 0;
  localparam int DATAMODE_LSB = 1;
  localparam int CTRLMODE_LSB = 3;
  localparam int DSTADDR_LSB  = 8;
  localparam int DATA_LSB     = 40;
  localparam int SRCADDR_LSB  = 72;

  typedef enum logic [1:0] {
    DM_BYTE   = 2'd0,
    DM_HALF   = 2'd1,
    DM_WORD   = 2'd2,
    DM_DOUBLE = 2'd3
  } datamode_e;

  // Packet view matching the offsets above (LSB = write bit).
  typedef struct packed {
    logic [31:0] srcaddr;
    logic [31:0] data;
    logic [31:0] dstaddr;
    logic [4:0]  ctrlmode;
    datamode_e   datamode;
    logic        write;
  } packet_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/emesh_responder_if.sv
// Request/response packet channel between an emesh initiator (master)
// and the responder (slave).
interface emesh_responder_if
  import emesh_pkg::*;
#(
  parameter int AW = EMESH_AW,
  parameter int PW = pw_of(AW)
) ();

  logic          access_in;
  logic [PW-1:0] packet_in;
  logic          wait_out;
  logic          access_out;
  logic [PW-1:0] packet_out;
  logic          wait_in;

  modport slave (
    input  access_in,
    input  packet_in,
    output wait_out,
    output access_out,
    output packet_out,
    input  wait_in
  );

  modport master (
    output access_in,
    output packet_in,
    input  wait_out,
    input  access_out,
    input  packet_out,
    output wait_in
  );

endinterface

// File: rtl/emesh_responder_mem.sv
// DEPTH x 32 register file: one byte-enabled write port that can also
// write the following word (double accesses), and two combinational read
// ports returning the word at idx and at idx+1 (wrapping).
module emesh_responder_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [IW-1:0] idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data,
  input  logic          wr_hi,
  input  logic [31:0]   wr_data_hi,
  output logic [31:0]   rd_data0,
  output logic [31:0]   rd_data1
);

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx_hi;

  // Index arithmetic wraps modulo DEPTH because DEPTH is a power of two.
  assign idx_hi   = idx + 1'b1;
  assign rd_data0 = mem[idx];
  assign rd_data1 = mem[idx_hi];

  // Byte-lane write at idx, optional full-word write at idx+1.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: this memory is deliberately reset; the model must read back
      // zeros after any reset, so it cannot be a plain RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
      if (wr_hi) mem[idx_hi] <= wr_data_hi;
    end
  end

endmodule

// File: rtl/emesh_responder.sv
// Memory-backed emesh target: decodes requests, checks alignment, updates
// the register file and returns read data through a one-deep response
// register that backpressures the requester while it cannot drain.
module emesh_responder
  import emesh_pkg::*;
#(
  parameter int AW    = EMESH_AW,
  parameter int PW    = pw_of(AW),
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                nreset,
  emesh_responder_if.slave    bus,
  output logic                err,
  output logic [7:0]          err_count
);

  localparam int IW = $clog2(DEPTH);

  packet_t       req;
  packet_t       rsp_next;
  logic          stall;
  logic          accept;
  logic          misaligned;
  logic          rd_go;
  logic          wr_go;
  logic [IW-1:0] idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_hi;
  logic [31:0]   rd_word0;
  logic [31:0]   rd_word1;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_data;
  rsp_state_e    state;
  logic          access_q;
  packet_t       packet_q;
  logic          unused_addr;

  assign req = packet_t'(bus.packet_in);
  assign idx = req.dstaddr[IW+1:2];

  // Upper address bits alias onto the same words.
  assign unused_addr = ^req.dstaddr[AW-1:IW+2];

  // Everything stalls, writes included, while a response is stuck.
  assign stall          = access_q & bus.wait_in;
  assign bus.wait_out   = stall;
  assign bus.access_out = access_q;
  assign bus.packet_out = packet_q;
  assign accept         = bus.access_in & ~stall;

  // Alignment check and request classification.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    misaligned = 1'b0;
    unique case (req.datamode)
      DM_BYTE:   misaligned = 1'b0;
      DM_HALF:   misaligned = req.dstaddr[0];
      DM_WORD:   misaligned = |req.dstaddr[1:0];
      DM_DOUBLE: misaligned = |req.dstaddr[2:0];
    endcase
    wr_go = accept & req.write & ~misaligned;
    rd_go = accept & ~req.write & ~misaligned;
  end

  // Write lane steering: data is replicated across lanes and the byte
  // enables pick the lanes that actually change.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req.data;
    wr_hi   = 1'b0;
    if (wr_go) begin
      unique case (req.datamode)
        DM_BYTE: begin
          wr_be   = 4'b0001 << req.dstaddr[1:0];
          wr_data = {4{req.data[7:0]}};
        end
        DM_HALF: begin
          wr_be   = req.dstaddr[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{req.data[15:0]}};
        end
        DM_WORD: wr_be = 4'b1111;
        DM_DOUBLE: begin
          wr_be = 4'b1111;
          wr_hi = 1'b1;
        end
      endcase
    end
  end

  emesh_responder_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk        (clk),
    .nreset     (nreset),
    .idx        (idx),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .wr_hi      (wr_hi),
    .wr_data_hi (req.srcaddr),
    .rd_data0   (rd_word0),
    .rd_data1   (rd_word1)
  );

  // Read lane extraction and response packet assembly. Aligned halves
  // only use offsets 0 and 2, so a single byte-granular shift serves all.
  always_comb begin
    rd_shift = rd_word0 >> {req.dstaddr[1:0], 3'b000};
    rd_data  = rd_word0;
    unique case (req.datamode)
      DM_BYTE:   rd_data = {24'h0, rd_shift[7:0]};
      DM_HALF:   rd_data = {16'h0, rd_shift[15:0]};
      DM_WORD:   rd_data = rd_word0;
      DM_DOUBLE: rd_data = rd_word0;
    endcase
    rsp_next          = '0;
    rsp_next.write    = 1'b1;
    rsp_next.datamode = req.datamode;
    rsp_next.ctrlmode = req.ctrlmode;
    rsp_next.dstaddr  = req.srcaddr;
    rsp_next.data     = rd_data;
    rsp_next.srcaddr  = (req.datamode == DM_DOUBLE) ? rd_word1 : 32'h0;
  end

  // Response FSM: a new read can replace the held packet only when the
  // old one drains in the same cycle (accept already implies that).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= RSP_EMPTY;
      access_q <= 1'b0;
      packet_q <= '0;
    end else begin
      unique case (state)
        RSP_EMPTY: begin
          if (rd_go) begin
            state    <= RSP_FULL;
            access_q <= 1'b1;
            packet_q <= rsp_next;
          end
        end
        RSP_FULL: begin
          if (rd_go) begin
            packet_q <= rsp_next;
          end else if (!bus.wait_in) begin
            state    <= RSP_EMPTY;
            access_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Dropped-request pulse and saturating drop counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      err <= accept & misaligned;
      if (accept && misaligned && err_count != 8'hFF) begin
        err_count <= err_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_emesh_responder.sv
// Directed bench for emesh_responder: a table of single-cycle requests
// with hand-computed results, then sequences for backpressure, counter
// saturation and asynchronous reset.
module tb_emesh_responder;

  localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, DBL = 2'd3;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       err;
  logic [7:0] err_count;
  int         total = 0;
  int         bad = 0;

  emesh_responder_if #(.AW(32)) bus ();

  emesh_responder #(.AW(32), .DEPTH(16)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  dm;
    logic [4:0]  ctrl;
    logic [31:0] dst;
    logic [31:0] data;
    logic [31:0] src;
    logic        exp_acc;
    logic [31:0] exp_data;
    logic [31:0] exp_src;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic wr, logic [1:0] dm, logic [4:0] ctrl,
                             logic [31:0] dst, logic [31:0] data, logic [31:0] src,
                             logic exp_acc, logic [31:0] exp_data, logic [31:0] exp_src,
                             logic exp_err, logic [7:0] exp_cnt);
    vec_t r;
    r.wr = wr; r.dm = dm; r.ctrl = ctrl; r.dst = dst; r.data = data; r.src = src;
    r.exp_acc = exp_acc; r.exp_data = exp_data; r.exp_src = exp_src;
    r.exp_err = exp_err; r.exp_cnt = exp_cnt;
    return r;
  endfunction

  function automatic logic [103:0] pkt(logic wr, logic [1:0] dm, logic [4:0] ctrl,
                                       logic [31:0] dst, logic [31:0] data, logic [31:0] src);
    return {src, data, dst, ctrl, dm, wr};
  endfunction

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] dm, input logic [4:0] ctrl,
                       input logic [31:0] dst, input logic [31:0] data, input logic [31:0] src);
    bus.access_in = 1'b1;
    bus.packet_in = pkt(wr, dm, ctrl, dst, data, src);
  endtask

  task automatic idle();
    bus.access_in = 1'b0;
    bus.packet_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [103:0] held;
  int           acc_seen;

  initial begin
    bus.access_in = 1'b0;
    bus.packet_in = '0;
    bus.wait_in   = 1'b0;

    //           wr    dm    ctrl   dst         data          src           acc  exp_data      exp_src       err cnt
    vecs.push_back(v(1'b1, WORD, 5'h00, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, WORD, 5'h03, 32'h08, 32'h0,        32'h1000,     1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b1, BYTE, 5'h00, 32'h05, 32'h123456AA, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h04, 32'h0,        32'h2000,     1'b1, 32'h0000AA00, 32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, BYTE, 5'h1F, 32'h05, 32'h0,        32'h2004,     1'b1, 32'h000000AA, 32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b1, HALF, 5'h00, 32'h06, 32'hFFFF1234, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, WORD, 5'h0A, 32'h04, 32'h0,        32'h2008,     1'b1, 32'h1234AA00, 32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, HALF, 5'h00, 32'h06, 32'h0,        32'h200C,     1'b1, 32'h00001234, 32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, HALF, 5'h00, 32'h04, 32'h0,        32'h2010,     1'b1, 32'h0000AA00, 32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b1, DBL,  5'h00, 32'h38, 32'h11111111, 32'h22222222, 1'b0, 32'h0,        32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b0, DBL,  5'h15, 32'h38, 32'h0,        32'h3000,     1'b1, 32'h11111111, 32'h22222222, 1'b0, 8'd0));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h00, 32'h0,        32'h3004,     1'b1, 32'h0,        32'h0,        1'b0, 8'd0));
    vecs.push_back(v(1'b1, DBL,  5'h00, 32'h3C, 32'h99999999, 32'h88888888, 1'b0, 32'h0,        32'h0,        1'b1, 8'd1));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h3C, 32'h0,        32'h3008,     1'b1, 32'h22222222, 32'h0,        1'b0, 8'd1));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h02, 32'h0,        32'h300C,     1'b0, 32'h0,        32'h0,        1'b1, 8'd2));
    vecs.push_back(v(1'b1, HALF, 5'h00, 32'h05, 32'h0000BEEF, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 8'd3));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h04, 32'h0,        32'h3010,     1'b1, 32'h1234AA00, 32'h0,        1'b0, 8'd3));
    vecs.push_back(v(1'b1, WORD, 5'h00, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 8'd3));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h00, 32'h0,        32'h3014,     1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 8'd3));
    vecs.push_back(v(1'b0, WORD, 5'h00, 32'h48, 32'h0,        32'h3018,     1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 8'd3));
    vecs.push_back(v(1'b0, BYTE, 5'h00, 32'h4B, 32'h0,        32'h301C,     1'b1, 32'h000000DE, 32'h0,        1'b0, 8'd3));

    // Reset state
    #12;
    check("rst_access_out", 104'(bus.access_out), 104'(0));
    check("rst_packet_out", bus.packet_out, '0);
    check("rst_wait_out", 104'(bus.wait_out), 104'(0));
    check("rst_err", 104'(err), 104'(0));
    check("rst_err_count", 104'(err_count), 104'(0));
    tick();
    nreset = 1'b1;

    // Table-driven single-cycle requests, wait_in low
    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].dm, vecs[i].ctrl, vecs[i].dst, vecs[i].data, vecs[i].src);
      tick();
      check($sformatf("vec%0d_access", i), 104'(bus.access_out), 104'(vecs[i].exp_acc));
      check($sformatf("vec%0d_err", i), 104'(err), 104'(vecs[i].exp_err));
      check($sformatf("vec%0d_err_count", i), 104'(err_count), 104'(vecs[i].exp_cnt));
      if (vecs[i].exp_acc)
        check($sformatf("vec%0d_packet", i), bus.packet_out,
              pkt(1'b1, vecs[i].dm, vecs[i].ctrl, vecs[i].src, vecs[i].exp_data, vecs[i].exp_src));
    end
    idle();
    tick();
    check("drain_access", 104'(bus.access_out), 104'(0));

    // Backpressure: stuck response stalls a pending write
    drive(1'b0, WORD, 5'h07, 32'h08, 32'h0, 32'h4000);
    tick();
    held = pkt(1'b1, WORD, 5'h07, 32'h4000, 32'hDEADBEEF, 32'h0);
    check("bp_first_packet", bus.packet_out, held);
    drive(1'b1, WORD, 5'h00, 32'h08, 32'h55555555, 32'h0);
    bus.wait_in = 1'b1;
    #1;
    check("bp_wait_out_comb", 104'(bus.wait_out), 104'(1));
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_c%0d_wait_out", c), 104'(bus.wait_out), 104'(1));
      check($sformatf("bp_c%0d_access", c), 104'(bus.access_out), 104'(1));
      check($sformatf("bp_c%0d_packet", c), bus.packet_out, held);
    end
    bus.wait_in = 1'b0;
    #1;
    check("bp_release_wait_out", 104'(bus.wait_out), 104'(0));
    tick();
    check("bp_release_access", 104'(bus.access_out), 104'(0));

    // Back-to-back reads replace the response every cycle
    drive(1'b0, WORD, 5'h00, 32'h00, 32'h0, 32'h5000);
    tick();
    check("b2b0_access", 104'(bus.access_out), 104'(1));
    check("b2b0_packet", bus.packet_out, pkt(1'b1, WORD, 5'h00, 32'h5000, 32'hCAFEF00D, 32'h0));
    drive(1'b0, WORD, 5'h00, 32'h04, 32'h0, 32'h5004);
    tick();
    check("b2b1_access", 104'(bus.access_out), 104'(1));
    check("b2b1_packet", bus.packet_out, pkt(1'b1, WORD, 5'h00, 32'h5004, 32'h1234AA00, 32'h0));
    drive(1'b0, WORD, 5'h00, 32'h08, 32'h0, 32'h5008);
    tick();
    check("b2b2_access", 104'(bus.access_out), 104'(1));
    check("b2b2_packet", bus.packet_out, pkt(1'b1, WORD, 5'h00, 32'h5008, 32'h55555555, 32'h0));
    idle();
    tick();
    check("b2b_drain", 104'(bus.access_out), 104'(0));

    // Error counter saturation: 300 misaligned reads
    acc_seen = 0;
    drive(1'b0, WORD, 5'h00, 32'h02, 32'h0, 32'h6000);
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.access_out) acc_seen++;
    end
    check("sat_err_count", 104'(err_count), 104'(255));
    check("sat_err_pulse", 104'(err), 104'(1));
    check("sat_no_response", 104'(acc_seen), 104'(0));
    idle();
    tick();
    check("sat_err_clear", 104'(err), 104'(0));
    check("sat_count_hold", 104'(err_count), 104'(255));

    // Asynchronous reset with a stuck response
    drive(1'b0, WORD, 5'h00, 32'h08, 32'h0, 32'h7000);
    bus.wait_in = 1'b1;
    tick();
    check("ar_pending", 104'(bus.access_out), 104'(1));
    idle();
    #2;
    nreset = 1'b0;
    #1;
    check("ar_access_drop", 104'(bus.access_out), 104'(0));
    check("ar_packet_clear", bus.packet_out, '0);
    check("ar_wait_out", 104'(bus.wait_out), 104'(0));
    check("ar_err_count", 104'(err_count), 104'(0));
    tick();
    nreset = 1'b1;
    bus.wait_in = 1'b0;
    drive(1'b0, WORD, 5'h00, 32'h08, 32'h0, 32'h7004);
    tick();
    check("ar_mem_word", bus.packet_out, pkt(1'b1, WORD, 5'h00, 32'h7004, 32'h0, 32'h0));
    drive(1'b0, DBL, 5'h00, 32'h38, 32'h0, 32'h7008);
    tick();
    check("ar_mem_double", bus.packet_out, pkt(1'b1, DBL, 5'h00, 32'h7008, 32'h0, 32'h0));
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
